// File: rtl/wallace_pipe_mult.sv
// Pipelined Wallace-tree multiplier, WIDTH x WIDTH -> 2*WIDTH, valid/ready on both sides.
// Define WALLACE_SIGNED_EN to add signed_mode (Baugh-Wooley two's-complement operation).
module wallace_pipe_mult #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned STAGES = 3
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [WIDTH-1:0]            a,
  input  logic [WIDTH-1:0]            b,
`ifdef WALLACE_SIGNED_EN
  input  logic                        signed_mode,
`endif
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [2*WIDTH-1:0]          prod,
  output logic [$clog2(STAGES+1)-1:0] occupancy
);

  localparam int unsigned PW = 2 * WIDTH;
  localparam int unsigned OW = $clog2(STAGES + 1);

  typedef logic [PW-1:0] row_t;
  typedef row_t          rows_t [WIDTH];

  function automatic int unsigned rows_after(input int unsigned n);
    return 2 * (n / 3) + (n % 3);
  endfunction

  function automatic int unsigned num_levels(input int unsigned n);
    int unsigned cnt;
    int unsigned r;
    cnt = 0;
    r   = n;
    for (int unsigned i = 0; i < 64; i++) begin
      if (r > 2) begin
        r   = rows_after(r);
        cnt = cnt + 1;
      end
    end
    return cnt;
  endfunction

  function automatic int unsigned rows_at_level(input int unsigned lvl);
    int unsigned r;
    r = WIDTH;
    for (int unsigned i = 0; i < 64; i++) begin
      if (i < lvl) r = rows_after(r);
    end
    return r;
  endfunction

  localparam int unsigned NL = num_levels(WIDTH);

`ifdef WALLACE_SIGNED_EN
  localparam row_t BW_CORR = (row_t'(1) << WIDTH) | (row_t'(1) << (PW - 1));

  // Cross terms involving exactly one sign bit are inverted; the matching
  // constant is added alongside the final carry-propagate add.
  function automatic rows_t gen_pp(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                   input logic sm);
    rows_t            r;
    logic [WIDTH-1:0] row;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      row = x & {WIDTH{y[i]}};
      if (sm) begin
        if (i == WIDTH - 1) row[WIDTH-2:0] = ~row[WIDTH-2:0];
        else                row[WIDTH-1]   = ~row[WIDTH-1];
      end
      r[i] = row_t'(row) << i;
    end
    return r;
  endfunction
`else
  function automatic rows_t gen_pp(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
    rows_t r;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      r[i] = row_t'(x & {WIDTH{y[i]}}) << i;
    end
    return r;
  endfunction
`endif

  // One Wallace level: each full triple of rows becomes sum + shifted carry,
  // leftover rows pass through; rows beyond the live count stay zero.
  function automatic rows_t csa_level(input rows_t r, input int unsigned n);
    rows_t       o;
    int unsigned g;
    g = n / 3;
    for (int unsigned i = 0; i < WIDTH; i++) o[i] = '0;
    for (int unsigned t = 0; t < WIDTH / 3; t++) begin
      if (t < g) begin
        o[2*t]   = r[3*t] ^ r[3*t+1] ^ r[3*t+2];
        o[2*t+1] = ((r[3*t] & r[3*t+1]) | (r[3*t] & r[3*t+2]) | (r[3*t+1] & r[3*t+2])) << 1;
      end
    end
    for (int unsigned p = 0; p < 2; p++) begin
      if (p < n % 3) o[2*g+p] = r[3*g+p];
    end
    return o;
  endfunction

  logic [STAGES-1:0] v_q, v_d;
  logic [STAGES-1:0] rdy;
  logic [STAGES-1:0] ld;
  logic [STAGES:0]   chain_v;
  logic [OW-1:0]     occ_q, occ_d;
  logic [PW-1:0]     prod_q, prod_d;
  logic              acc, rel;
  rows_t             pp;

`ifdef WALLACE_SIGNED_EN
  always_comb pp = gen_pp(a, b, signed_mode);
`else
  always_comb pp = gen_pp(a, b);
`endif

  // Stage k may load when it is empty or its occupant moves on this edge.
  always_comb begin
    rdy     = '0;
    ld      = '0;
    v_d     = v_q;
    chain_v = {v_q, in_valid};
    rdy[STAGES-1] = !v_q[STAGES-1] || out_ready;
    for (int unsigned j = 1; j < STAGES; j++) begin
      rdy[STAGES-1-j] = !v_q[STAGES-1-j] || rdy[STAGES-j];
    end
    for (int unsigned k = 0; k < STAGES; k++) begin
      if (rdy[k]) v_d[k] = chain_v[k];
      ld[k] = rdy[k] && chain_v[k];
    end
    acc   = in_valid && rdy[0];
    rel   = v_q[STAGES-1] && out_ready;
    occ_d = occ_q + OW'(acc) - OW'(rel);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v_q    <= '0;
      occ_q  <= '0;
      prod_q <= '0;
    end else begin
      v_q   <= v_d;
      occ_q <= occ_d;
      if (ld[STAGES-1]) prod_q <= prod_d;
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int unsigned LO = (k * NL) / STAGES;
    localparam int unsigned HI = ((k + 1) * NL) / STAGES;

    rows_t src;
    rows_t cmp;
`ifdef WALLACE_SIGNED_EN
    logic  src_s;
`endif

    if (k == 0) begin : g_first
      always_comb src = pp;
`ifdef WALLACE_SIGNED_EN
      always_comb src_s = signed_mode;
`endif
    end else begin : g_next
      always_comb src = g_stage[k-1].g_mid.rows_q;
`ifdef WALLACE_SIGNED_EN
      always_comb src_s = g_stage[k-1].g_mid.sgn_q;
`endif
    end

    always_comb begin
      cmp = src;
      for (int unsigned l = LO; l < HI; l++) begin
        cmp = csa_level(cmp, rows_at_level(l));
      end
    end

    if (k < STAGES - 1) begin : g_mid
      rows_t rows_q;
`ifdef WALLACE_SIGNED_EN
      logic  sgn_q;
`endif
      always_ff @(posedge clk) begin
        if (ld[k]) begin
          rows_q <= cmp;
`ifdef WALLACE_SIGNED_EN
          sgn_q  <= src_s;
`endif
        end
      end
    end else begin : g_last
      // All levels are done here, so at most two rows are non-zero.
      always_comb begin
        prod_d = '0;
        for (int unsigned i = 0; i < WIDTH; i++) prod_d = prod_d + cmp[i];
`ifdef WALLACE_SIGNED_EN
        if (src_s) prod_d = prod_d + BW_CORR;
`endif
      end
    end
  end

  assign in_ready  = rdy[0];
  assign out_valid = v_q[STAGES-1];
  assign prod      = prod_q;
  assign occupancy = occ_q;

endmodule
